// File: rtl/gcd_controller.sv
// gcd_controller: sequencing FSM for a 16-bit subtractive GCD datapath.
// Loads two operands over a valid/ready handshake, then alternates
// compare/subtract until A == B, and reports done, err, timeout and iter_cnt.
// Optional iteration limit: define GCD_TIMEOUT_EN to stop after MAX_ITER steps.
module gcd_controller #(
  parameter int DATA_W   = 16,
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              gt,
  input  logic              lt,
  input  logic              eq,
  output logic              lda,
  output logic              ldb,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_cnt
);

`ifdef GCD_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B, DONE
  } state_t;

  state_t state, state_next;

  logic zero_flag;
  logic err_q;
  logic timeout_q;
  logic clear_run;
  logic zero_seen;
  logic inc_iter;
  logic set_err;
  logic set_timeout;

  // State register; async reset always returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and state-decoded datapath controls.
  always_comb begin
    state_next  = state;
    op_ready    = 1'b0;
    lda         = 1'b0;
    ldb         = 1'b0;
    sel1        = 1'b0;
    sel2        = 1'b0;
    sel_in      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    clear_run   = 1'b0;
    zero_seen   = 1'b0;
    inc_iter    = 1'b0;
    set_err     = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_run  = 1'b1;
          state_next = LOAD_A;
        end
      end
      LOAD_A: begin
        busy     = 1'b1;
        op_ready = 1'b1;
        if (op_valid) begin
          lda        = 1'b1;
          sel_in     = 1'b1;
          zero_seen  = (data_in == '0);
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        busy     = 1'b1;
        op_ready = 1'b1;
        if (op_valid) begin
          ldb        = 1'b1;
          sel_in     = 1'b1;
          zero_seen  = (data_in == '0);
          state_next = CMP;
        end
      end
      CMP: begin
        busy = 1'b1;
        if (zero_flag) begin
          set_err    = 1'b1;
          state_next = DONE;
        end else if (eq) begin
          state_next = DONE;
        end else if (TIMEOUT_EN && (iter_cnt == ITER_LIMIT)) begin
          set_err     = 1'b1;
          set_timeout = 1'b1;
          state_next  = DONE;
        end else if (gt) begin
          state_next = SUB_A;
        end else if (lt) begin
          state_next = SUB_B;
        end else begin
          state_next = DONE;
        end
      end
      SUB_A: begin
        busy       = 1'b1;
        lda        = 1'b1;
        sel2       = 1'b1;
        inc_iter   = 1'b1;
        state_next = CMP;
      end
      SUB_B: begin
        busy       = 1'b1;
        ldb        = 1'b1;
        sel1       = 1'b1;
        inc_iter   = 1'b1;
        state_next = CMP;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Run status: cleared on an accepted start, held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt  <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      if (clear_run) begin
        iter_cnt  <= '0;
        err_q     <= 1'b0;
        timeout_q <= 1'b0;
        zero_flag <= 1'b0;
      end
      if (zero_seen)                      zero_flag <= 1'b1;
      if (inc_iter && (iter_cnt != '1))   iter_cnt  <= iter_cnt + 1'b1;
      if (set_err)                        err_q     <= 1'b1;
      if (set_timeout)                    timeout_q <= 1'b1;
    end
  end

  assign err     = err_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: surrounds the controller with a small A/B
// datapath and checks every cycle of each run against a Euclid-based model.
module tb_gcd_controller;

  localparam int DATA_W   = 16;
  localparam int ITER_W   = 16;
  localparam int MAX_ITER = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] data_in;
  logic              gt, lt, eq;
  logic              lda, ldb, sel1, sel2, sel_in;
  logic              busy, done, err, timeout;
  logic [ITER_W-1:0] iter_cnt;

  gcd_controller #(.DATA_W(DATA_W), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .op_valid(op_valid), .op_ready(op_ready),
    .data_in(data_in), .gt(gt), .lt(lt), .eq(eq), .lda(lda), .ldb(ldb),
    .sel1(sel1), .sel2(sel2), .sel_in(sel_in), .busy(busy), .done(done),
    .err(err), .timeout(timeout), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  // Datapath the controller drives: A/B registers, muxes, subtractor, comparator.
  logic [DATA_W-1:0] reg_a = '0;
  logic [DATA_W-1:0] reg_b = '0;
  logic [DATA_W-1:0] x_bus, y_bus, sub_out;
  assign x_bus   = sel1 ? reg_b : reg_a;
  assign y_bus   = sel2 ? reg_b : reg_a;
  assign sub_out = x_bus - y_bus;
  assign gt = reg_a > reg_b;
  assign lt = reg_a < reg_b;
  assign eq = reg_a == reg_b;

  always @(posedge clk) begin
    if (lda) reg_a <= sel_in ? data_in : sub_out;
    if (ldb) reg_b <= sel_in ? data_in : sub_out;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Expected behaviour of the current run.
  bit          run_active = 1'b0;
  int          start_cyc, exp_lat, exp_steps, sa, sb, done_e;
  logic [15:0] exp_gcd;
  bit          exp_err, exp_to;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Subtractive step count from Euclid quotients: sum(q) - 1.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output int steps, output logic [15:0] g, output bit zero);
    int x, y, t, s;
    zero  = (a == 0) || (b == 0);
    steps = 0;
    g     = 0;
    if (!zero) begin
      x = a; y = b; s = 0;
      while (y != 0) begin
        s += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      steps = s - 1;
      g     = 16'(x);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the expected run.
  always @(negedge clk) begin
    int e;
    if (run_active) begin
      e = cyc - start_cyc;
      if (done) done_e = e;
      checkOutput("done", done, (e == exp_lat));
      checkOutput("busy", busy, (e >= 1 && e < exp_lat));
      checkOutput("op_ready", op_ready, (e >= 1 && e <= sa + sb + 2));
      if (e >= 1 && e <= sa + 1) checkOutput("lda_load", lda, (e == sa + 1));
      if (e >= sa + 2 && e <= sa + sb + 2) checkOutput("ldb_load", ldb, (e == sa + sb + 2));
      if (exp_err && !exp_to && e > sa + sb + 2) checkOutput("no_load_zero", lda | ldb, 0);
      if (e == exp_lat) begin
        checkOutput("err", err, exp_err);
        checkOutput("timeout", timeout, exp_to);
        checkOutput("iter_cnt", iter_cnt, exp_steps);
        if (!exp_err) checkOutput("result", reg_a, exp_gcd);
      end
    end
  end

  // One GCD run: optional operand stalls, stray start pulses, or a reset abort.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input int stall_a, input int stall_b,
                               input int busy_start_e, input bit start_in_done,
                               input int abort_e);
    int steps;
    bit zero;
    model(a, b, steps, exp_gcd, zero);
    exp_err = zero;
    exp_to  = 1'b0;
`ifdef GCD_TIMEOUT_EN
    if (steps > MAX_ITER) begin
      steps   = MAX_ITER;
      exp_err = 1'b1;
      exp_to  = 1'b1;
    end
`endif
    exp_steps = steps;
    sa = stall_a;
    sb = stall_b;
    exp_lat = 2 * steps + 4 + sa + sb;
    done_e  = -1;
    @(posedge clk); #1;
    start_cyc  = cyc;
    start      = 1'b1;
    op_valid   = 1'b0;
    run_active = 1'b1;
    for (int k = 1; k <= exp_lat + 2; k++) begin
      @(posedge clk); #1;
      start = (k == busy_start_e) || (start_in_done && k == exp_lat);
      if (k <= sa + 1) begin
        op_valid = (k == sa + 1);
        data_in  = a;
      end else if (k <= sa + sb + 2) begin
        op_valid = (k == sa + sb + 2);
        data_in  = b;
      end else begin
        op_valid = 1'b1;
        data_in  = 16'hbeef;
      end
      if (k == abort_e) begin
        checkOutput("in_sub_b", {ldb, sel1, sel2, sel_in}, 4'b1100);
        run_active = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_outputs", {op_ready, lda, ldb, sel1, sel2, sel_in,
                                    busy, done, err, timeout}, 0);
        checkOutput("rst_iter", iter_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
    end
    run_active = 1'b0;
    start      = 1'b0;
    op_valid   = 1'b0;
  endtask

  initial begin
    int          s;
    logic [15:0] g;
    bit          z;
    rst = 1'b1; start = 1'b0; op_valid = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {op_ready, lda, ldb, sel1, sel2, sel_in,
                                  busy, done, err, timeout}, 0);
    checkOutput("reset_iter", iter_cnt, 0);
    rst = 1'b0;

    model(16'd48, 16'd18, s, g, z);
    checkOutput("model_steps_48_18", s, 4);
    checkOutput("model_gcd_48_18", g, 6);
    model(16'd35, 16'd14, s, g, z);
    checkOutput("model_gcd_35_14", g, 7);
    model(16'd0, 16'd5, s, g, z);
    checkOutput("model_zero", z, 1);

    applyStimulus(16'd48, 16'd18, 0, 0, -1, 1'b0, -1);
    checkOutput("lat_48_18", done_e, 12);
    checkOutput("iter_48_18", iter_cnt, 4);
    checkOutput("res_48_18", reg_a, 6);

    applyStimulus(16'd7, 16'd7, 0, 0, -1, 1'b0, -1);
    checkOutput("lat_7_7", done_e, 4);
    checkOutput("iter_7_7", iter_cnt, 0);

    applyStimulus(16'd0, 16'd5, 0, 0, -1, 1'b0, -1);
    checkOutput("err_0_5", err, 1);
    checkOutput("iter_0_5", iter_cnt, 0);

    applyStimulus(16'd35, 16'd14, 3, 2, -1, 1'b0, -1);
    checkOutput("res_35_14", reg_a, 7);

    applyStimulus(16'd1, 16'd1500, 0, 0, -1, 1'b0, -1);
`ifdef GCD_TIMEOUT_EN
    checkOutput("iter_limit", iter_cnt, 1000);
    checkOutput("timeout_flag", timeout, 1);
`else
    checkOutput("iter_1_1500", iter_cnt, 1499);
    checkOutput("res_1_1500", reg_a, 1);
`endif

    applyStimulus(16'd48, 16'd18, 0, 0, -1, 1'b0, 8);
    applyStimulus(16'd48, 16'd18, 0, 0, 5, 1'b0, -1);
    checkOutput("lat_busy_start", done_e, 12);
    applyStimulus(16'd270, 16'd192, 0, 0, -1, 1'b1, -1);
    checkOutput("iter_270_192", iter_cnt, 10);
    applyStimulus(16'd18, 16'd48, 1, 0, -1, 1'b0, -1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
